// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit.
package ctrl_pkg;

   localparam int unsigned STATE_W    = 4;
   localparam int unsigned ALU_CTRL_W = 3;
   localparam int unsigned CMD_W      = 4;
   localparam int unsigned COND_W     = 4;
   localparam int unsigned FLAGS_W    = 4;
   localparam int unsigned SEL_W      = 2;

   typedef enum logic [STATE_W-1:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BRANCH
   } state_t;

   // ALUControl codes
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_ORR = 3'b011;
   localparam logic [ALU_CTRL_W-1:0] ALU_EOR = 3'b100;

   // Data-processing cmd field values
   localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
   localparam logic [CMD_W-1:0] CMD_EOR = 4'b0001;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
   localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
   localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;

   // Condition field codes
   localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
   localparam logic [COND_W-1:0] COND_NE = 4'b0001;
   localparam logic [COND_W-1:0] COND_CS = 4'b0010;
   localparam logic [COND_W-1:0] COND_CC = 4'b0011;
   localparam logic [COND_W-1:0] COND_MI = 4'b0100;
   localparam logic [COND_W-1:0] COND_PL = 4'b0101;
   localparam logic [COND_W-1:0] COND_VS = 4'b0110;
   localparam logic [COND_W-1:0] COND_VC = 4'b0111;
   localparam logic [COND_W-1:0] COND_HI = 4'b1000;
   localparam logic [COND_W-1:0] COND_LS = 4'b1001;
   localparam logic [COND_W-1:0] COND_GE = 4'b1010;
   localparam logic [COND_W-1:0] COND_LT = 4'b1011;
   localparam logic [COND_W-1:0] COND_GT = 4'b1100;
   localparam logic [COND_W-1:0] COND_LE = 4'b1101;
   localparam logic [COND_W-1:0] COND_AL = 4'b1110;
   localparam logic [COND_W-1:0] COND_NV = 4'b1111;

   // ALUSrcB encodings
   localparam logic [SEL_W-1:0] SRCB_RM   = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   // ResultSrc encodings
   localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
   localparam logic [SEL_W-1:0] RES_READDATA  = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

   // Op field classes
   localparam logic [SEL_W-1:0] OP_DP  = 2'b00;
   localparam logic [SEL_W-1:0] OP_MEM = 2'b01;
   localparam logic [SEL_W-1:0] OP_BR  = 2'b10;

   localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/cond_unit.sv
// Architectural NZCV flags, latched condition result and condition evaluation.
module cond_unit
   import ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [COND_W-1:0]  Cond,
   input  logic [FLAGS_W-1:0] ALUFlags,
   input  logic [1:0]         FlagW,
   input  logic               FlagEn,
   input  logic               LatchCond,
   output logic               CondExR
);

   logic [FLAGS_W-1:0] flags;
   logic               cond_ex;
   logic               n, z, c, v;

   // Flags register: NZ and CV halves update independently, only for executed instructions
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= '0;
      end else if (FlagEn && CondExR) begin
         if (FlagW[1]) flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0]) flags[1:0] <= ALUFlags[1:0];
      end
   end

   // Condition result captured in DECODE and held for the rest of the instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         CondExR <= 1'b0;
      end else if (LatchCond) begin
         CondExR <= cond_ex;
      end
   end

   // Evaluate the condition field against the registered flags
   always_comb begin
      {n, z, c, v} = flags;
      cond_ex = 1'b0;
      case (Cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, ALU decoder and condition unit.
module multicycle_controller
   import ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [COND_W-1:0]     Cond,
   input  logic [1:0]            Op,
   input  logic [5:0]            Funct,
   input  logic [3:0]            Rd,
   input  logic [FLAGS_W-1:0]    ALUFlags,
   output logic                  PCWrite,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic                  IRWrite,
   output logic                  AdrSrc,
   output logic [1:0]            RegSrc,
   output logic                  ALUSrcA,
   output logic [SEL_W-1:0]      ALUSrcB,
   output logic [SEL_W-1:0]      ResultSrc,
   output logic [1:0]            ImmSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl
);

   state_t                  state, state_next;
   logic [CMD_W-1:0]        cmd;
   logic                    s_bit;
   logic [ALU_CTRL_W-1:0]   dp_alu_ctrl;
   logic                    no_write;
   logic                    cmd_arith;
   logic                    is_cmp;
   logic [1:0]              flag_w;
   logic                    flag_en;
   logic                    latch_cond;
   logic                    cond_ex_r;
   logic                    rd_is_pc;
   logic                    dp_wb_en;

   assign cmd      = Funct[4:1];
   assign s_bit    = Funct[0];
   assign is_cmp   = (cmd == CMD_CMP);
   assign rd_is_pc = (Rd == REG_PC);
   assign dp_wb_en = cond_ex_r & ~no_write;

   // NZ update on S or CMP; CV only for the arithmetic commands
   assign flag_w[1] = s_bit | is_cmp;
   assign flag_w[0] = flag_w[1] & cmd_arith;

   cond_unit u_cond_unit (
      .clk       (clk),
      .reset     (reset),
      .Cond      (Cond),
      .ALUFlags  (ALUFlags),
      .FlagW     (flag_w),
      .FlagEn    (flag_en),
      .LatchCond (latch_cond),
      .CondExR   (cond_ex_r)
   );

   // ALU decoder for data-processing commands
   always_comb begin
      dp_alu_ctrl = ALU_ADD;
      no_write    = 1'b0;
      cmd_arith   = 1'b0;
      case (cmd)
         CMD_ADD: begin dp_alu_ctrl = ALU_ADD; cmd_arith = 1'b1; end
         CMD_SUB: begin dp_alu_ctrl = ALU_SUB; cmd_arith = 1'b1; end
         CMD_CMP: begin dp_alu_ctrl = ALU_SUB; cmd_arith = 1'b1; no_write = 1'b1; end
         CMD_AND: dp_alu_ctrl = ALU_AND;
         CMD_ORR: dp_alu_ctrl = ALU_ORR;
         CMD_EOR: dp_alu_ctrl = ALU_EOR;
         default: begin dp_alu_ctrl = ALU_ADD; no_write = 1'b1; end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:    state_next = DECODE;
         DECODE: begin
            case (Op)
               OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
               OP_MEM:  state_next = MEMADR;
               OP_BR:   state_next = BRANCH;
               default: state_next = FETCH;
            endcase
         end
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         ALUWB:    state_next = FETCH;
         MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    state_next = MEMWB;
         MEMWB:    state_next = FETCH;
         MEMWR:    state_next = FETCH;
         BRANCH:   state_next = FETCH;
         default:  state_next = FETCH;
      endcase
   end

   // Datapath enables and selects; write enables are held low during reset
   always_comb begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RM;
      ResultSrc  = RES_ALUOUT;
      ALUControl = ALU_ADD;
      flag_en    = 1'b0;
      latch_cond = 1'b0;
      RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};
      ImmSrc     = Op;
      case (state)
         FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         DECODE: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            latch_cond = 1'b1;
         end
         EXECUTER: begin
            ALUSrcB    = SRCB_RM;
            ALUControl = dp_alu_ctrl;
            flag_en    = 1'b1;
         end
         EXECUTEI: begin
            ALUSrcB    = SRCB_IMM;
            ALUControl = dp_alu_ctrl;
            flag_en    = 1'b1;
         end
         ALUWB: begin
            ResultSrc = RES_ALUOUT;
            PCWrite   = dp_wb_en & rd_is_pc;
            RegWrite  = dp_wb_en & ~rd_is_pc;
         end
         MEMADR: begin
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
         end
         MEMWB: begin
            ResultSrc = RES_READDATA;
            PCWrite   = cond_ex_r & rd_is_pc;
            RegWrite  = cond_ex_r & ~rd_is_pc;
         end
         MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex_r;
         end
         BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            PCWrite   = cond_ex_r;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         IRWrite  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] ALUControl;

   int checks   = 0;
   int failures = 0;

   // Reference model state: architectural flags and the condition outcome of the current instruction
   logic [3:0] m_flags;
   logic       m_condexr;

   logic [16:0] obs;
   assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .RegSrc     (RegSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected output word; RegSrc and ImmSrc follow Op in every cycle
   function automatic logic [16:0] exp_vec(input logic pcw, input logic memw, input logic regw,
                                           input logic irw, input logic adr, input logic srca,
                                           input logic [1:0] srcb, input logic [1:0] res,
                                           input logic [2:0] alu, input logic [1:0] op);
      logic [1:0] regsrc;
      regsrc = {op == 2'b01, op == 2'b10};
      return {pcw, memw, regw, irw, adr, regsrc, srca, srcb, res, op, alu};
   endfunction

   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return c && !z;
         4'd9:    return !c || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Instruction-level ALU semantics: operation code and whether the result is discarded
   task automatic alu_ref(input logic [3:0] cmd, output logic [2:0] code, output logic nw,
                          output logic arith);
      code = 3'b000; nw = 1'b0; arith = 1'b0;
      if      (cmd == 4'b0100) begin code = 3'b000; arith = 1'b1; end
      else if (cmd == 4'b0010) begin code = 3'b001; arith = 1'b1; end
      else if (cmd == 4'b1010) begin code = 3'b001; arith = 1'b1; nw = 1'b1; end
      else if (cmd == 4'b0000) code = 3'b010;
      else if (cmd == 4'b1100) code = 3'b011;
      else if (cmd == 4'b0001) code = 3'b100;
      else nw = 1'b1;
   endtask

   // One cycle: compare mid-cycle, then advance past the next rising edge
   task automatic step(input string tag, input logic [16:0] exp);
      @(negedge clk);
      check_eq(tag, 32'(obs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction cycle by cycle; entered just after the edge that starts FETCH
   task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input logic [3:0] af, input bit abort_at_memadr);
      logic [2:0] code;
      logic       nw, arith, we, upd;
      logic [3:0] cmd;
      Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
      cmd = funct[4:1];
      step("fetch", exp_vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 3'b000, op));
      m_condexr = cond_ok(cond, m_flags);
      step("decode", exp_vec(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, op));
      case (op)
         2'b00: begin
            alu_ref(cmd, code, nw, arith);
            if (m_condexr) begin
               upd = funct[0] || (cmd == 4'b1010);
               if (upd) m_flags[3:2] = af[3:2];
               if (upd && arith) m_flags[1:0] = af[1:0];
            end
            step(funct[5] ? "exec_i" : "exec_r",
                 exp_vec(0, 0, 0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00, 2'b00, code, op));
            we = m_condexr && !nw;
            step("aluwb", exp_vec(we && rd == 4'd15, 0, we && rd != 4'd15, 0, 0, 0,
                                  2'b00, 2'b00, 3'b000, op));
         end
         2'b01: begin
            if (abort_at_memadr) return;
            step("memadr", exp_vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, op));
            if (funct[0]) begin
               step("memrd", exp_vec(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, op));
               step("memwb", exp_vec(m_condexr && rd == 4'd15, 0, m_condexr && rd != 4'd15,
                                     0, 0, 0, 2'b00, 2'b01, 3'b000, op));
            end else begin
               step("memwr", exp_vec(0, m_condexr, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, op));
            end
         end
         2'b10: step("branch", exp_vec(m_condexr, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, op));
         default: ;
      endcase
   endtask

   initial begin
      reset = 1'b1;
      Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
      m_flags = 4'd0; m_condexr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_enables", 32'(obs[16:13]), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // ADD R1,R2,R3 then SUBS setting Z, followed by BEQ (taken) and BNE (not taken)
      run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'($urandom), 1'b0);
      run_instr(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0110, 1'b0);
      run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);
      run_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);

      // Flags=0011, then ANDS keeps C/V; branches probe N, Z, C, V
      run_instr(4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0011, 1'b0);
      run_instr(4'b1110, 2'b00, 6'b000001, 4'd3, 4'b1010, 1'b0);
      run_instr(4'b0110, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);
      run_instr(4'b0100, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);
      run_instr(4'b0010, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);
      run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);

      // CMP clears flags; Rd=15 data write goes to PC; LDR and STR with failing EQ
      run_instr(4'b1110, 2'b00, 6'b010101, 4'd4, 4'b0000, 1'b0);
      run_instr(4'b1110, 2'b00, 6'b101000, 4'd15, 4'b0000, 1'b0);
      run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, 1'b0);
      run_instr(4'b0000, 2'b01, 6'b011000, 4'd2, 4'b0000, 1'b0);
      run_instr(4'b1111, 2'b00, 6'b001001, 4'd5, 4'b1111, 1'b0);

      // Reset in MEMADR after Z was set: enables low, flags cleared, FETCH on release
      run_instr(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100, 1'b0);
      run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("reset_in_memadr", 32'(obs[16:13]), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("reset_in_fetch", 32'(obs[16:13]), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_flags = 4'd0; m_condexr = 1'b0;
      run_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);
      run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0);

      // Undefined Op=11 returns straight to FETCH
      run_instr(4'b1110, 2'b11, 6'b111111, 4'd1, 4'b1111, 1'b0);
      run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000, 1'b0);

      // Randomized instruction stream, conditions biased toward AL
      for (int i = 0; i < 300; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
         run_instr(c, 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM datapath. It sits directly upstream of the ALU and drives its ALUControl input, and it also consumes the ALU's ALUFlags output.
- Contains three parts:
  - the main state machine that sequences fetch/decode/execute/memory/writeback;
  - the ALU decoder;
  - the condition unit, which holds the architectural NZCV flags register and evaluates the instruction condition field.
- Emits every datapath enable and mux select.

Parameters:
- none. All encodings are fixed constants in ctrl_pkg.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- Cond  input  4  instruction bits [31:28], condition field
- Op  input  2  instruction bits [27:26]
- Funct  input  6  instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S or L
- Rd  input  4  instruction bits [15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  data memory write enable
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- RegSrc  output  2  [0]=1 reads R15 for Rn; [1]=1 reads Rd for the second read port
- ALUSrcA  output  1  0=Rn, 1=PC
- ALUSrcB  output  2  00=Rm, 01=ExtImm, 10=constant 4
- ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ImmSrc  output  2  equals Op
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR

Behaviour:
- Reset behaviour:
  - State becomes FETCH, Flags becomes 0000, CondExR becomes 0.
  - While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0.
  - Reset asserted mid-instruction abandons the instruction; FETCH starts on the first cycle after reset falls.
- Outputs are combinational from state and inputs (Moore plus the gating terms below). Unlisted enables are 0; unlisted selects are don't-care, driven as 0.
- FETCH:
  - Outputs: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - Latches CondExR <= CondEx.
  - Next state by Op:
    - Op=00 and Funct[5]=0 -> EXECUTER
    - Op=00 and Funct[5]=1 -> EXECUTEI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (undefined instruction, no side effects)
- EXECUTER: ALUSrcA=0, ALUSrcB=00, decoded ALUControl. Next: ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, decoded ALUControl. Next: ALUWB.
- ALU decode from cmd=Funct[4:1]:
  - 0100 -> ADD
  - 0010 -> SUB
  - 1010 (CMP) -> SUB, with NoWrite
  - 0000 -> AND
  - 1100 -> ORR
  - 0001 -> EOR
  - any other cmd -> ADD, with NoWrite
- Flag update, at the end of EXECUTER/EXECUTEI only, when CondExR=1:
  - Flags[3:2] (NZ) <= ALUFlags[3:2] if S=1 or CMP.
  - Flags[1:0] (CV) <= ALUFlags[1:0] only if additionally cmd is ADD/SUB/CMP.
  - Logical operations with S=1 preserve C and V.
- ALUWB: ResultSrc=00.
  - If CondExR and not NoWrite: RegWrite=1 when Rd!=15; PCWrite=1 instead when Rd==15.
  - Next: FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD. Next: MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite/PCWrite gated exactly as in ALUWB. Next: FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExR. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondExR. Next: FETCH.
- RegSrc[0]=(Op==10) and RegSrc[1]=(Op==01) in every state.
- CondEx, evaluated from the registered Flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 -> 0
- Latency in cycles: data-processing 4, load 5, store 4, branch 3.
- A failed condition still walks all states with every write suppressed; it never shortens the sequence.

Decomposition:
- ctrl_pkg holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH);
  - the ALUControl codes;
  - the condition-code constants;
  - the ALUSrcB and ResultSrc encodings.
- Sub-module cond_unit contains the Flags register, the CondExR register and CondEx evaluation. It takes clk, reset, Cond, ALUFlags, FlagW[1:0], FlagEn and LatchCond.

Test Plan:
- ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000, Rd=1) after reset -> states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB; Flags stay 0000.
- SUBS with ALUFlags=0110 in EXECUTER -> Flags=0110. A following BEQ (Cond=0000, Op=10) gives PCWrite=1 in BRANCH; BNE gives PCWrite=0 there.
- ANDS with ALUFlags=1010 while Flags=0011 -> Flags=1011 (C and V preserved).
- CMP (Funct=010101) -> ALUControl=001 and the flags update; RegWrite=0 in ALUWB.
- LDR (Op=01, Funct[0]=1) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, with AdrSrc=1 in MEMRD and ResultSrc=01 plus RegWrite=1 in MEMWB. STR with Cond=0000 and Z=0 -> MemWrite=0 in MEMWR.
- Reset asserted in MEMADR -> next state FETCH, Flags=0000, all enables 0 during reset. Op=11 -> DECODE goes to FETCH with no writes.
